// File: rtl/fpu_mul_if.sv
// Handshake and operand/result bus between the FPU control logic and the multiplier core.
interface fpu_mul_if;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (output start, operand_a, operand_b,
                  input  busy, done, result, flags);
  modport slave  (input  start, operand_a, operand_b,
                  output busy, done, result, flags);
endinterface

// File: rtl/fpu_mul_core.sv
// Multi-cycle IEEE-754 single-precision multiplier: radix-2 shift-add mantissa product,
// round-to-nearest-even, denormals flushed to zero on input.
module fpu_mul_core #(
  parameter int unsigned MANT_W   = 24,
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic     clk,
  input  logic     arst,
  fpu_mul_if.slave bus
);

  localparam int unsigned FRAC_W = MANT_W - 1;
  localparam int unsigned PW     = 2 * MANT_W;
  localparam int unsigned CNT_W  = $clog2(MANT_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [7:0]        ea_q, ea_d, eb_q, eb_d;
  logic [FRAC_W-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic [FRAC_W-1:0] mant_q, mant_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              inc_c;
  logic [MANT_W-1:0] rnd_c;
  logic signed [9:0] exp_r_c;

  // Operand classification; a zero exponent field flushes the operand to zero.
  assign a_nan  = (ea_q == 8'hFF) && (fa_q != '0);
  assign b_nan  = (eb_q == 8'hFF) && (fb_q != '0);
  assign a_inf  = (ea_q == 8'hFF) && (fa_q == '0);
  assign b_inf  = (eb_q == 8'hFF) && (fb_q == '0);
  assign a_zero = (ea_q == 8'h00);
  assign b_zero = (eb_q == 8'h00);

  // Round-to-nearest-even; a carry out of the fraction bumps the exponent.
  assign inc_c   = guard_q & (sticky_q | mant_q[0]);
  assign rnd_c   = {1'b0, mant_q} + MANT_W'(inc_c);
  assign exp_r_c = exp_q + (rnd_c[FRAC_W] ? 10'sd1 : 10'sd0);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_UNPACK;
          sign_d  = bus.operand_a[31] ^ bus.operand_b[31];
          ea_d    = bus.operand_a[30:23];
          eb_d    = bus.operand_b[30:23];
          fa_d    = bus.operand_a[FRAC_W-1:0];
          fb_d    = bus.operand_b[FRAC_W-1:0];
          flags_d = '0;
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
          result_d = 32'h7FC0_0000;
          flags_d  = 4'b1000;
        end else if (a_inf || b_inf) begin
          result_d = {sign_q, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
          result_d = {sign_q, 31'h0};
        end else begin
          state_d  = S_MUL;
          mplier_d = {1'b1, fb_q};
          acc_d    = '0;
          cnt_d    = '0;
          exp_d    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(10'(EXP_BIAS));
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + (PW'({1'b1, fa_q}) << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        state_d = S_ROUND;
        if (acc_q[PW-1]) begin
          mant_d   = acc_q[PW-2 -: FRAC_W];
          guard_d  = acc_q[PW-2-FRAC_W];
          sticky_d = |acc_q[PW-3-FRAC_W:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          mant_d   = acc_q[PW-3 -: FRAC_W];
          guard_d  = acc_q[PW-3-FRAC_W];
          sticky_d = |acc_q[PW-4-FRAC_W:0];
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (exp_r_c >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          flags_d  = 4'b0101;
        end else if (exp_r_c <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_r_c[7:0], rnd_c[FRAC_W-1:0]};
          flags_d  = {3'b000, guard_q | sticky_q};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_UNPACK) || (state_d == S_MUL) ||
             (state_d == S_NORM)   || (state_d == S_ROUND);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fpu_mul_core.sv
// Self-checking bench for fpu_mul_core: directed vector table, hand-written corner
// sequences, and random operands against an arithmetic reference model.
module tb_fpu_mul_core;

  logic clk;
  logic arst;
  int   errors = 0;
  int   checks = 0;

  fpu_mul_if bus ();

  fpu_mul_core #(.MANT_W(24), .EXP_BIAS(127)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency is counted in rising edges after the edge that accepts start.
  localparam int LAT_NORMAL  = 27;
  localparam int LAT_SPECIAL = 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, remainder-based round-half-even.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
    int unsigned ea, eb;
    int e, sh;
    longint unsigned p, q, rem, half;
    logic s, an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    r = 32'h0; f = 4'h0; lat = LAT_SPECIAL;
    if (an || bn || (az && bi) || (ai && bz)) begin
      r = 32'h7FC0_0000; f = 4'b1000;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r = {s, 31'h0};
    end else begin
      lat = LAT_NORMAL;
      p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e = int'(ea) + int'(eb) - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0011;
      end else begin
        r = {s, 8'(e), 23'(q)}; f = {3'b000, rem != 0};
      end
    end
  endfunction

  // One full operation; returns result, flags and latency, and checks the busy/done shape.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    bit busy_bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    lat = 0;
    busy_bad = 0;
    while (!bus.done && lat < 60) begin
      if (!bus.busy) busy_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result;
    f = bus.flags;
    check("busy_during_op", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int unsigned sel;
    sel = $urandom_range(0, 99);
    v = $urandom;
    if (sel < 70)      v[30:23] = 8'($urandom_range(100, 154));
    else if (sel < 80) v[30:23] = 8'($urandom_range(1, 20));
    else if (sel < 90) v[30:23] = 8'($urandom_range(235, 254));
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    int lat, elat, cyc;
    bit saw;

    vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, LAT_NORMAL};
    vecs[1] = '{32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 4'b0000, LAT_NORMAL};
    vecs[2] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, LAT_NORMAL};
    vecs[3] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, LAT_SPECIAL};
    vecs[4] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, LAT_SPECIAL};
    vecs[5] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, LAT_NORMAL};
    vecs[6] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, LAT_NORMAL};
    vecs[7] = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, LAT_SPECIAL};
    vecs[8] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, LAT_SPECIAL};
    vecs[9] = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000, LAT_SPECIAL};

    arst = 1'b1;
    bus.start = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_result", bus.result,      32'd0);
    check("reset_flags",  32'(bus.flags),  32'd0);
    @(negedge clk);
    arst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Flags clear on accept while the previous result is held (previous vec was not overflow; redo it).
    run_op(32'h7F00_0000, 32'h7F00_0000, r, f, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = 32'h3FC0_0000;
    bus.operand_b = 32'h4000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("accept_flags_cleared", 32'(bus.flags), 32'd0);
    check("accept_result_held", bus.result, 32'h7F80_0000);
    check("accept_busy", 32'(bus.busy), 32'd1);
    // Re-pulse start with other operands while busy: must be ignored.
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = 32'h4100_0000;
    bus.operand_b = 32'h4100_0000;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 5;
    while (!bus.done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("repulse_latency", 32'(cyc), 32'(LAT_NORMAL));
    check("repulse_result", bus.result, 32'h4040_0000);
    // Start during the DONE cycle is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = 32'h4100_0000;
    bus.operand_b = 32'h4100_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    // Start in the IDLE cycle right after done is accepted.
    run_op(32'h4100_0000, 32'h4100_0000, r, f, lat);
    check("b2b_result", r, 32'h4280_0000);
    check("b2b_latency", 32'(lat), 32'(LAT_NORMAL));

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = 32'h3FC0_0000;
    bus.operand_b = 32'h4000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    check("midrst_busy",   32'(bus.busy),  32'd0);
    check("midrst_done",   32'(bus.done),  32'd0);
    check("midrst_result", bus.result,     32'd0);
    check("midrst_flags",  32'(bus.flags), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    saw = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw = 1;
    end
    check("midrst_no_done", 32'(saw), 32'd0);
    run_op(32'h3FC0_0000, 32'h4000_0000, r, f, lat);
    check("postrst_result", r, 32'h4040_0000);
    check("postrst_latency", 32'(lat), 32'(LAT_NORMAL));

    // Random operands against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, b;
      a = rand_operand();
      b = rand_operand();
      ref_mul(a, b, er, ef, elat);
      run_op(a, b, r, f, lat);
      check($sformatf("rnd%0d_result a=%h b=%h", n, a, b), r, er);
      check($sformatf("rnd%0d_flags a=%h b=%h", n, a, b), 32'(f), 32'(ef));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
